// File: rtl/fight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fight_pkg
//  Description : Shared types and defaults for the attack resolver: combo
//                encodings, per-player FSM states, timing and damage values.
//  Revision    : 1.0 - initial release
// ============================================================================
package fight_pkg;

  typedef enum logic [1:0] {
    COMBO_NONE    = 2'd0,
    COMBO_NORMAL  = 2'd1,
    COMBO_SPECIAL = 2'd2,
    COMBO_SUPER   = 2'd3
  } combo_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WINDUP  = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RECOVER = 3'd3,
    S_STUN    = 3'd4
  } state_t;

  localparam int         DEF_WINDUP_N = 2;
  localparam int         DEF_WINDUP_S = 4;
  localparam int         DEF_WINDUP_X = 6;
  localparam int         DEF_RECOVER  = 3;
  localparam int         DEF_STUN_T   = 8;
  localparam logic [8:0] DEF_DMG_N    = 9'd10;
  localparam logic [8:0] DEF_DMG_S    = 9'd20;
  localparam logic [8:0] DEF_DMG_X    = 9'd40;

  // True while the player is anywhere inside an attack (windup to recovery)
  function automatic logic in_attack(input state_t s);
    return (s == S_WINDUP) || (s == S_ACTIVE) || (s == S_RECOVER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/attack_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : attack_fsm
//  Description : One player's attack sequencer: latches a combo request,
//                times windup/active/recovery and holds stun when hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module attack_fsm
  import fight_pkg::*;
#(
  parameter int WINDUP_N = DEF_WINDUP_N,
  parameter int WINDUP_S = DEF_WINDUP_S,
  parameter int WINDUP_X = DEF_WINDUP_X,
  parameter int RECOVER  = DEF_RECOVER,
  parameter int STUN_T   = DEF_STUN_T
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_over,
  input  logic [1:0] combo,
  input  logic       stun_hit,
  output state_t     state,
  output combo_t     move
);

  logic [3:0] cnt;

  // Counter reload for the windup of the requested move (count to 0 inclusive)
  function automatic logic [3:0] windup_load(input logic [1:0] c);
    case (c)
      2'd1:    return 4'(WINDUP_N - 1);
      2'd2:    return 4'(WINDUP_S - 1);
      2'd3:    return 4'(WINDUP_X - 1);
      default: return 4'd0;
    endcase
  endfunction

  // Phase sequencing; an incoming clean hit overrides whatever the player was doing
  always_ff @(posedge clk) begin
    if (reset || game_over) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      move  <= COMBO_NONE;
    end else if (stun_hit) begin
      state <= S_STUN;
      cnt   <= 4'(STUN_T - 1);
      move  <= COMBO_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (combo != 2'd0) begin
            move  <= combo_t'(combo);
            cnt   <= windup_load(combo);
            state <= S_WINDUP;
          end
        end
        S_WINDUP: begin
          if (cnt == 4'd0) state <= S_ACTIVE;
          else             cnt   <= cnt - 4'd1;
        end
        S_ACTIVE: begin
          cnt   <= 4'(RECOVER - 1);
          state <= S_RECOVER;
        end
        S_RECOVER, S_STUN: begin
          if (cnt == 4'd0) begin
            state <= S_IDLE;
            move  <= COMBO_NONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/attack_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : attack_resolver
//  Description : Two-player attack sequencer and hit arbiter. Resolves active
//                attacks against range and block, handles trades, injects
//                stun and emits one-cycle damage pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module attack_resolver
  import fight_pkg::*;
#(
  parameter int         WINDUP_N = DEF_WINDUP_N,
  parameter int         WINDUP_S = DEF_WINDUP_S,
  parameter int         WINDUP_X = DEF_WINDUP_X,
  parameter int         RECOVER  = DEF_RECOVER,
  parameter int         STUN_T   = DEF_STUN_T,
  parameter logic [8:0] DMG_N    = DEF_DMG_N,
  parameter logic [8:0] DMG_S    = DEF_DMG_S,
  parameter logic [8:0] DMG_X    = DEF_DMG_X
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_over,
  input  logic       in_range,
  input  logic [1:0] p1_combo,
  input  logic [1:0] p2_combo,
  input  logic       p1_block,
  input  logic       p2_block,
  output logic       p1_attacking,
  output logic       p2_attacking,
  output logic       p1_stunned,
  output logic       p2_stunned,
  output logic [8:0] dmg_to_p1,
  output logic       dmg_p1_vld,
  output logic [8:0] dmg_to_p2,
  output logic       dmg_p2_vld
);

  state_t     s1, s2;
  combo_t     m1, m2;
  logic       hit_on_p1, hit_on_p2;
  logic       stun_p1, stun_p2;
  logic [8:0] amt_to_p1, amt_to_p2;

  function automatic logic [8:0] dmg_of(input combo_t m);
    case (m)
      COMBO_NORMAL:  return DMG_N;
      COMBO_SPECIAL: return DMG_S;
      COMBO_SUPER:   return DMG_X;
      default:       return 9'd0;
    endcase
  endfunction

  attack_fsm #(
    .WINDUP_N(WINDUP_N), .WINDUP_S(WINDUP_S), .WINDUP_X(WINDUP_X),
    .RECOVER(RECOVER), .STUN_T(STUN_T)
  ) u_p1 (
    .clk(clk), .reset(reset), .game_over(game_over), .combo(p1_combo),
    .stun_hit(stun_p1), .state(s1), .move(m1)
  );

  attack_fsm #(
    .WINDUP_N(WINDUP_N), .WINDUP_S(WINDUP_S), .WINDUP_X(WINDUP_X),
    .RECOVER(RECOVER), .STUN_T(STUN_T)
  ) u_p2 (
    .clk(clk), .reset(reset), .game_over(game_over), .combo(p2_combo),
    .stun_hit(stun_p2), .state(s2), .move(m2)
  );

  // Cross-resolution from current (pre-stun) states, so a same-tick trade hits both ways
  always_comb begin
    hit_on_p2 = (s1 == S_ACTIVE) && in_range && !game_over;
    hit_on_p1 = (s2 == S_ACTIVE) && in_range && !game_over;
    amt_to_p2 = p2_block ? (dmg_of(m1) >> 2) : dmg_of(m1);
    amt_to_p1 = p1_block ? (dmg_of(m2) >> 2) : dmg_of(m2);
    stun_p2   = hit_on_p2 && !p2_block;
    stun_p1   = hit_on_p1 && !p1_block;
  end

  // Registered damage pulses; the value is forced to 0 whenever no pulse is present
  always_ff @(posedge clk) begin
    if (reset) begin
      dmg_p1_vld <= 1'b0;
      dmg_p2_vld <= 1'b0;
      dmg_to_p1  <= 9'd0;
      dmg_to_p2  <= 9'd0;
    end else begin
      dmg_p1_vld <= hit_on_p1;
      dmg_p2_vld <= hit_on_p2;
      dmg_to_p1  <= hit_on_p1 ? amt_to_p1 : 9'd0;
      dmg_to_p2  <= hit_on_p2 ? amt_to_p2 : 9'd0;
    end
  end

  assign p1_attacking = in_attack(s1);
  assign p2_attacking = in_attack(s2);
  assign p1_stunned   = (s1 == S_STUN);
  assign p2_stunned   = (s2 == S_STUN);

endmodule
`default_nettype wire

// File: tb/tb_attack_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_attack_resolver
//  Description : Self-checking bench for attack_resolver. Expected damage
//                pulses are queued when a request is driven and popped by a
//                monitor when the DUT pulses; tasks check phase durations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_attack_resolver;

  logic       clk = 1'b0;
  logic       reset, game_over, in_range;
  logic [1:0] p1_combo, p2_combo;
  logic       p1_block, p2_block;
  logic       p1_attacking, p2_attacking, p1_stunned, p2_stunned;
  logic [8:0] dmg_to_p1, dmg_to_p2;
  logic       dmg_p1_vld, dmg_p2_vld;

  typedef struct {
    int         tick;
    logic [8:0] dmg;
  } exp_t;

  exp_t exp_p1[$];
  exp_t exp_p2[$];
  int   cyc     = 0;
  int   vectors = 0;
  int   errors  = 0;

  attack_resolver dut (
    .clk(clk), .reset(reset), .game_over(game_over), .in_range(in_range),
    .p1_combo(p1_combo), .p2_combo(p2_combo),
    .p1_block(p1_block), .p2_block(p2_block),
    .p1_attacking(p1_attacking), .p2_attacking(p2_attacking),
    .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
    .dmg_to_p1(dmg_to_p1), .dmg_p1_vld(dmg_p1_vld),
    .dmg_to_p2(dmg_to_p2), .dmg_p2_vld(dmg_p2_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the head of its queue in tick and value
  always @(negedge clk) begin
    exp_t e;
    if (dmg_p2_vld) begin
      vectors++;
      if (exp_p2.size() == 0) begin
        errors++;
        $display("FAIL p2_pulse unexpected at tick %0d dmg=%0d", cyc, dmg_to_p2);
      end else begin
        e = exp_p2.pop_front();
        if (e.tick !== cyc || e.dmg !== dmg_to_p2) begin
          errors++;
          $display("FAIL p2_pulse got tick %0d dmg %0d, want tick %0d dmg %0d", cyc, dmg_to_p2, e.tick, e.dmg);
        end
      end
    end else if (dmg_to_p2 !== 9'd0) begin
      vectors++;
      errors++;
      $display("FAIL p2_dmg_idle got %0d want 0 at tick %0d", dmg_to_p2, cyc);
    end
    if (dmg_p1_vld) begin
      vectors++;
      if (exp_p1.size() == 0) begin
        errors++;
        $display("FAIL p1_pulse unexpected at tick %0d dmg=%0d", cyc, dmg_to_p1);
      end else begin
        e = exp_p1.pop_front();
        if (e.tick !== cyc || e.dmg !== dmg_to_p1) begin
          errors++;
          $display("FAIL p1_pulse got tick %0d dmg %0d, want tick %0d dmg %0d", cyc, dmg_to_p1, e.tick, e.dmg);
        end
      end
    end else if (dmg_to_p1 !== 9'd0) begin
      vectors++;
      errors++;
      $display("FAIL p1_dmg_idle got %0d want 0 at tick %0d", dmg_to_p1, cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit to_p2, input int tick, input logic [8:0] dmg);
    exp_t e;
    e.tick = tick;
    e.dmg  = dmg;
    if (to_p2) exp_p2.push_back(e);
    else       exp_p1.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; game_over = 1'b0; in_range = 1'b0;
    p1_combo = 2'd0; p2_combo = 2'd0; p1_block = 1'b0; p2_block = 1'b0;
    step(); step();
    vectors++;
    if ({p1_attacking, p2_attacking, p1_stunned, p2_stunned, dmg_p1_vld, dmg_p2_vld} !== 6'b0 ||
        dmg_to_p1 !== 9'd0 || dmg_to_p2 !== 9'd0) begin
      errors++;
      $display("FAIL reset_state flags=%b dmg1=%0d dmg2=%0d want all 0",
               {p1_attacking, p2_attacking, p1_stunned, p2_stunned, dmg_p1_vld, dmg_p2_vld}, dmg_to_p1, dmg_to_p2);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal_hit();
    int att = 0, stn = 0;
    in_range = 1'b1;
    p1_combo = 2'd1;
    push(1'b1, cyc + 4, 9'd10);
    for (int i = 0; i < 14; i++) begin
      step();
      p1_combo = 2'd0;
      att += int'(p1_attacking);
      stn += int'(p2_stunned);
    end
    vectors++;
    if (att != 6) begin errors++; $display("FAIL normal_attacking_ticks got %0d want 6", att); end
    vectors++;
    if (stn != 8) begin errors++; $display("FAIL normal_p2_stun_ticks got %0d want 8", stn); end
    vectors++;
    if (exp_p2.size() != 0) begin errors++; $display("FAIL normal_missing_pulse got %0d pending want 0", exp_p2.size()); end
  endtask

  task automatic test_block_super();
    int stn = 0;
    in_range = 1'b1;
    p2_block = 1'b1;
    p1_combo = 2'd3;
    push(1'b1, cyc + 8, 9'd10);
    for (int i = 0; i < 14; i++) begin
      step();
      p1_combo = 2'd0;
      stn += int'(p2_stunned);
    end
    p2_block = 1'b0;
    vectors++;
    if (stn != 0) begin errors++; $display("FAIL block_p2_stun_ticks got %0d want 0", stn); end
    vectors++;
    if (exp_p2.size() != 0) begin errors++; $display("FAIL block_missing_pulse got %0d pending want 0", exp_p2.size()); end
  endtask

  task automatic test_trade();
    int s1 = 0, s2 = 0;
    in_range = 1'b1;
    p1_combo = 2'd1;
    p2_combo = 2'd1;
    push(1'b1, cyc + 4, 9'd10);
    push(1'b0, cyc + 4, 9'd10);
    for (int i = 0; i < 14; i++) begin
      step();
      p1_combo = 2'd0;
      p2_combo = 2'd0;
      s1 += int'(p1_stunned);
      s2 += int'(p2_stunned);
    end
    vectors++;
    if (s1 != 8 || s2 != 8) begin errors++; $display("FAIL trade_stun_ticks got p1=%0d p2=%0d want 8/8", s1, s2); end
    vectors++;
    if (exp_p1.size() != 0 || exp_p2.size() != 0) begin
      errors++; $display("FAIL trade_missing_pulse got %0d/%0d pending want 0/0", exp_p1.size(), exp_p2.size());
    end
  endtask

  task automatic test_cancel();
    int att2 = 0, stn2 = 0;
    in_range = 1'b1;
    p2_combo = 2'd3;
    step();
    p2_combo = 2'd0;
    att2 += int'(p2_attacking);
    p1_combo = 2'd1;
    push(1'b1, cyc + 4, 9'd10);
    for (int i = 0; i < 16; i++) begin
      step();
      p1_combo = 2'd0;
      att2 += int'(p2_attacking);
      stn2 += int'(p2_stunned);
    end
    vectors++;
    if (att2 != 4) begin errors++; $display("FAIL cancel_p2_attacking_ticks got %0d want 4", att2); end
    vectors++;
    if (stn2 != 8) begin errors++; $display("FAIL cancel_p2_stun_ticks got %0d want 8", stn2); end
    vectors++;
    if (exp_p2.size() != 0) begin errors++; $display("FAIL cancel_missing_pulse got %0d pending want 0", exp_p2.size()); end
  endtask

  task automatic test_reset_mid();
    in_range = 1'b1;
    p1_combo = 2'd2;
    step();
    p1_combo = 2'd0;
    step();
    reset = 1'b1;
    step();
    vectors++;
    if ({p1_attacking, p2_attacking, p1_stunned, p2_stunned, dmg_p1_vld, dmg_p2_vld} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_flags got %b want 000000",
               {p1_attacking, p2_attacking, p1_stunned, p2_stunned, dmg_p1_vld, dmg_p2_vld});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_game_over();
    int busy = 0;
    in_range = 1'b1;
    p1_combo = 2'd1;
    step();
    p1_combo = 2'd0;
    game_over = 1'b1;
    p2_combo = 2'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      busy += int'(p1_attacking | p2_attacking | p1_stunned | p2_stunned | dmg_p1_vld | dmg_p2_vld);
    end
    p2_combo = 2'd0;
    game_over = 1'b0;
    vectors++;
    if (busy != 0) begin errors++; $display("FAIL game_over_outputs got %0d busy ticks want 0", busy); end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_whiff();
    int att = 0;
    in_range = 1'b0;
    p1_combo = 2'd2;
    for (int i = 0; i < 12; i++) begin
      step();
      p1_combo = 2'd0;
      att += int'(p1_attacking);
    end
    vectors++;
    if (att != 8) begin errors++; $display("FAIL whiff_attacking_ticks got %0d want 8", att); end
    vectors++;
    if (p1_attacking !== 1'b0) begin errors++; $display("FAIL whiff_idle got %b want 0", p1_attacking); end
  endtask

  task automatic test_restun();
    int stn = 0, guard = 0;
    in_range = 1'b1;
    p1_combo = 2'd1;
    push(1'b1, cyc + 4, 9'd10);
    step();
    p1_combo = 2'd0;
    stn += int'(p2_stunned);
    while (p1_attacking && guard < 20) begin
      step();
      stn += int'(p2_stunned);
      guard++;
    end
    vectors++;
    if (guard >= 20) begin errors++; $display("FAIL restun_timeout got %0d ticks want < 20", guard); end
    p1_combo = 2'd1;
    push(1'b1, cyc + 4, 9'd10);
    for (int i = 0; i < 16; i++) begin
      step();
      p1_combo = 2'd0;
      stn += int'(p2_stunned);
    end
    vectors++;
    if (stn != 15) begin errors++; $display("FAIL restun_stun_ticks got %0d want 15", stn); end
    vectors++;
    if (exp_p2.size() != 0) begin errors++; $display("FAIL restun_missing_pulse got %0d pending want 0", exp_p2.size()); end
  endtask

  initial begin
    test_reset();
    test_normal_hit();
    test_block_super();
    test_trade();
    test_cancel();
    test_reset_mid();
    test_game_over();
    test_whiff();
    test_restun();
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
